receptor_nota_buzzer: RTL and testbench



---
 rtl/receptor_nota_buzzer.sv | 179 +++++++++++++++++
 tb/tb_receptor_nota_buzzer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/receptor_nota_buzzer.sv
// -----------------------------------------------------------------------------
// receptor_nota_buzzer
// Receives the 3-bit note code sent by the game top level. The code is
// synchronised and debounced, and the selected note is then played as a
// square wave on the buzzer pin for a fixed number of clock cycles.
//
// Ports:
//   clock       in   system clock (50 MHz nominal)
//   reset       in   synchronous, active-low reset
//   arduino_in  in   [2:0] note code: 0 = silence, 1..7 = do..si
//   buzzer      out  square-wave tone
//   tocando     out  high while a note is playing
//   nota        out  [2:0] code of the note being played, 0 when idle
//   fim_nota    out  one-cycle pulse when a note completes its full duration
//   db_estado   out  [1:0] FSM state (0 idle, 1 sync, 2 play, 3 end)
// -----------------------------------------------------------------------------
module receptor_nota_buzzer #(
   parameter int DURACAO_CICLOS = 25000000,
   parameter int ESTAVEL_CICLOS = 4,
   parameter int DIV_SIM        = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] arduino_in,
   output logic       buzzer,
   output logic       tocando,
   output logic [2:0] nota,
   output logic       fim_nota,
   output logic [1:0] db_estado
);

   localparam int DW = (DURACAO_CICLOS > 1) ? $clog2(DURACAO_CICLOS) : 1;
   localparam int SW = $clog2(ESTAVEL_CICLOS + 1);
   localparam logic [DW-1:0] DUR_ULTIMO = DW'(DURACAO_CICLOS - 1);
   localparam logic [SW-1:0] ESTAVEL_MAX = SW'(ESTAVEL_CICLOS);

   typedef enum logic [1:0] {
      OCIOSO     = 2'd0,
      SINCRONIZA = 2'd1,
      TOCA       = 2'd2,
      FIM        = 2'd3
   } estado_t;

   // Half period in cycles for each note code, scaled down by DIV_SIM and
   // never allowed to drop below one cycle.
   function automatic logic [16:0] meio_periodo(input logic [2:0] c);
      int unsigned base;
      case (c)
         3'd1:    base = 95556;
         3'd2:    base = 85131;
         3'd3:    base = 75843;
         3'd4:    base = 71586;
         3'd5:    base = 63776;
         3'd6:    base = 56818;
         3'd7:    base = 50619;
         default: base = 1;
      endcase
      base = base / DIV_SIM;
      if (base < 1)
         base = 1;
      return base[16:0];
   endfunction

   logic [2:0]    sinc1;
   logic [2:0]    s_cod;
   logic [SW-1:0] estab_cnt;
   logic          estavel;
   logic [2:0]    ultimo_cod;
   logic [2:0]    nota_reg;
   logic [DW-1:0] dur_cnt;
   logic [16:0]   meio_cnt;
   logic [16:0]   meio_lim;
   logic          buzzer_reg;
   logic          carrega;
   estado_t       state_reg;
   estado_t       state_next;

   // Two-flop synchroniser plus stability counter. The counter restarts on the
   // edge where s_cod takes a new value and saturates at ESTAVEL_CICLOS.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sinc1     <= '0;
         s_cod     <= '0;
         estab_cnt <= '0;
      end else begin
         sinc1 <= arduino_in;
         s_cod <= sinc1;
         if (sinc1 != s_cod)
            estab_cnt <= '0;
         else if (estab_cnt != ESTAVEL_MAX)
            estab_cnt <= estab_cnt + 1'b1;
      end
   end

   assign estavel  = (estab_cnt == ESTAVEL_MAX);
   assign meio_lim = meio_periodo(nota_reg) - 17'd1;

   // State register
   always_ff @(posedge clock) begin
      if (!reset)
         state_reg <= OCIOSO;
      else
         state_reg <= state_next;
   end

   // Next-state logic. carrega marks the cycle in which a new note is latched,
   // either on first entry to TOCA or on a retrigger while already playing.
   always_comb begin
      state_next = state_reg;
      carrega    = 1'b0;
      case (state_reg)
         OCIOSO: begin
            if (s_cod != 3'd0 && s_cod != ultimo_cod)
               state_next = SINCRONIZA;
         end
         SINCRONIZA: begin
            // estab_cnt == 0 means s_cod changed on the last edge
            if (estab_cnt == '0)
               state_next = OCIOSO;
            else if (estavel && s_cod != 3'd0) begin
               carrega    = 1'b1;
               state_next = TOCA;
            end
         end
         TOCA: begin
            // A retrigger beats the end of the duration in the same cycle
            if (estavel && s_cod != 3'd0 && s_cod != nota_reg)
               carrega = 1'b1;
            else if (dur_cnt == DUR_ULTIMO)
               state_next = FIM;
         end
         FIM: begin
            state_next = OCIOSO;
         end
         default: state_next = OCIOSO;
      endcase
   end

   // Note datapath: stored code, duration counter and tone generator.
   always_ff @(posedge clock) begin
      if (!reset) begin
         ultimo_cod <= '0;
         nota_reg   <= '0;
         dur_cnt    <= '0;
         meio_cnt   <= '0;
         buzzer_reg <= 1'b0;
      end else begin
         // Returning to a stable 0 re-arms replay of the same note
         if (estavel && s_cod == 3'd0)
            ultimo_cod <= '0;
         if (carrega) begin
            nota_reg   <= s_cod;
            ultimo_cod <= s_cod;
            dur_cnt    <= '0;
            meio_cnt   <= '0;
            buzzer_reg <= 1'b0;
         end else if (state_reg == TOCA) begin
            dur_cnt <= dur_cnt + 1'b1;
            if (meio_cnt == meio_lim) begin
               meio_cnt   <= '0;
               buzzer_reg <= ~buzzer_reg;
            end else begin
               meio_cnt <= meio_cnt + 17'd1;
            end
         end
      end
   end

   // Outputs decoded from registers only, so they move on the state edge.
   // The tone and code are masked outside TOCA so FIM and idle read as 0.
   always_comb begin
      tocando   = (state_reg == TOCA);
      nota      = (state_reg == TOCA) ? nota_reg : 3'd0;
      buzzer    = (state_reg == TOCA) && buzzer_reg;
      fim_nota  = (state_reg == FIM);
      db_estado = state_reg;
   end

endmodule

// File: tb/tb_receptor_nota_buzzer.sv
// -----------------------------------------------------------------------------
// tb_receptor_nota_buzzer
// Directed bench for receptor_nota_buzzer with DURACAO_CICLOS=100,
// ESTAVEL_CICLOS=4, DIV_SIM=10000 (half periods 9,8,7,7,6,5,5).
// Inputs are changed 1 time unit after a rising edge, so the first edge that
// samples a new code is "edge 1"; TOCA is then entered 6 edges later, at
// edge 7 counted from the change.
// -----------------------------------------------------------------------------
module tb_receptor_nota_buzzer;

   logic       clock;
   logic       reset;
   logic [2:0] arduino_in;
   logic       buzzer;
   logic       tocando;
   logic [2:0] nota;
   logic       fim_nota;
   logic [1:0] db_estado;

   int errors = 0;
   int checks = 0;

   receptor_nota_buzzer #(
      .DURACAO_CICLOS(100),
      .ESTAVEL_CICLOS(4),
      .DIV_SIM(10000)
   ) dut (
      .clock(clock),
      .reset(reset),
      .arduino_in(arduino_in),
      .buzzer(buzzer),
      .tocando(tocando),
      .nota(nota),
      .fim_nota(fim_nota),
      .db_estado(db_estado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic settle_zero;
      arduino_in = 3'd0;
      repeat (10) tick;
   endtask

   task automatic test_reset;
      int n;
      logic [1:0] db_at3;
      reset = 1'b0;
      arduino_in = 3'd5;
      repeat (3) tick;
      checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer: got %b want 0", buzzer); end
      checks++; if (tocando !== 1'b0) begin errors++; $display("FAIL reset_tocando: got %b want 0", tocando); end
      checks++; if (nota !== 3'd0) begin errors++; $display("FAIL reset_nota: got %0d want 0", nota); end
      checks++; if (fim_nota !== 1'b0) begin errors++; $display("FAIL reset_fim: got %b want 0", fim_nota); end
      checks++; if (db_estado !== 2'd0) begin errors++; $display("FAIL reset_estado: got %0d want 0", db_estado); end
      reset = 1'b1;
      n = 0;
      db_at3 = 2'bxx;
      while (tocando !== 1'b1 && n < 30) begin
         tick;
         n++;
         if (n == 3) db_at3 = db_estado;
      end
      checks++; if (db_at3 !== 2'd1) begin errors++; $display("FAIL reset_sinc_state: got %0d want 1", db_at3); end
      checks++; if (n !== 7) begin errors++; $display("FAIL reset_latency: got %0d edges want 7", n); end
      checks++; if (nota !== 3'd5) begin errors++; $display("FAIL reset_note_code: got %0d want 5", nota); end
      n = 0;
      while (fim_nota !== 1'b1 && n < 200) begin
         tick;
         n++;
      end
      checks++; if (n !== 100) begin errors++; $display("FAIL reset_note_len: got %0d want 100", n); end
      $display("test_reset: note 5 started after release and ended after %0d cycles", n);
      settle_zero;
   endtask

   task automatic test_basic;
      int n;
      logic exp_bz;
      arduino_in = 3'd1;
      n = 0;
      while (tocando !== 1'b1 && n < 30) begin
         tick;
         n++;
      end
      checks++; if (n !== 7) begin errors++; $display("FAIL basic_latency: got %0d want 7", n); end
      checks++; if (nota !== 3'd1 || buzzer !== 1'b0) begin errors++; $display("FAIL basic_entry: nota=%0d buzzer=%b want 1/0", nota, buzzer); end
      for (int i = 1; i <= 101; i++) begin
         tick;
         if (i < 100) begin
            exp_bz = ((i / 9) % 2) == 1;
            checks++;
            if (tocando !== 1'b1 || nota !== 3'd1 || buzzer !== exp_bz || fim_nota !== 1'b0) begin
               errors++;
               $display("FAIL basic_play c%0d: toc=%b nota=%0d bz=%b fim=%b want 1/1/%b/0", i, tocando, nota, buzzer, fim_nota, exp_bz);
            end
         end else if (i == 100) begin
            checks++;
            if (fim_nota !== 1'b1 || tocando !== 1'b0 || nota !== 3'd0 || buzzer !== 1'b0 || db_estado !== 2'd3) begin
               errors++;
               $display("FAIL basic_fim: fim=%b toc=%b nota=%0d bz=%b st=%0d want 1/0/0/0/3", fim_nota, tocando, nota, buzzer, db_estado);
            end
         end else begin
            checks++;
            if (fim_nota !== 1'b0 || db_estado !== 2'd0 || nota !== 3'd0) begin
               errors++;
               $display("FAIL basic_after: fim=%b st=%0d nota=%0d want 0/0/0", fim_nota, db_estado, nota);
            end
         end
      end
      $display("test_basic: note 1 played 100 cycles with half period 9");
      settle_zero;
   endtask

   task automatic test_glitch;
      int played;
      played = 0;
      arduino_in = 3'd3;
      repeat (3) tick;
      arduino_in = 3'd0;
      repeat (15) begin
         tick;
         if (tocando === 1'b1) played++;
      end
      checks++; if (played !== 0) begin errors++; $display("FAIL glitch_tocando: high for %0d cycles want 0", played); end
      checks++; if (db_estado !== 2'd0) begin errors++; $display("FAIL glitch_estado: got %0d want 0", db_estado); end
      $display("test_glitch: 3-cycle code 3 rejected");
   endtask

   task automatic test_retrigger;
      int n;
      int j;
      logic exp_bz;
      arduino_in = 3'd2;
      n = 0;
      while (tocando !== 1'b1 && n < 30) begin
         tick;
         n++;
      end
      checks++; if (n !== 7 || nota !== 3'd2) begin errors++; $display("FAIL retrig_entry: edges=%0d nota=%0d want 7/2", n, nota); end
      for (int i = 1; i <= 146; i++) begin
         tick;
         if (i < 46) begin
            exp_bz = ((i / 8) % 2) == 1;
            checks++;
            if (tocando !== 1'b1 || nota !== 3'd2 || buzzer !== exp_bz || fim_nota !== 1'b0) begin
               errors++;
               $display("FAIL retrig_old c%0d: toc=%b nota=%0d bz=%b fim=%b want 1/2/%b/0", i, tocando, nota, buzzer, fim_nota, exp_bz);
            end
         end else if (i < 146) begin
            j = i - 46;
            exp_bz = ((j / 5) % 2) == 1;
            checks++;
            if (tocando !== 1'b1 || nota !== 3'd6 || buzzer !== exp_bz || fim_nota !== 1'b0) begin
               errors++;
               $display("FAIL retrig_new c%0d: toc=%b nota=%0d bz=%b fim=%b want 1/6/%b/0", i, tocando, nota, buzzer, fim_nota, exp_bz);
            end
         end else begin
            checks++;
            if (fim_nota !== 1'b1 || tocando !== 1'b0) begin
               errors++;
               $display("FAIL retrig_fim: fim=%b toc=%b want 1/0", fim_nota, tocando);
            end
         end
         // code 6 is first sampled at TOCA cycle 40
         if (i == 39) arduino_in = 3'd6;
      end
      $display("test_retrigger: note 2 replaced by note 6 at cycle 46, end at cycle 146");
      settle_zero;
   endtask

   task automatic test_same_code;
      int rises;
      int fims;
      int n;
      logic prev;
      rises = 0;
      fims = 0;
      prev = 1'b0;
      arduino_in = 3'd4;
      for (int i = 0; i < 300; i++) begin
         tick;
         if (tocando === 1'b1 && prev === 1'b0) rises++;
         if (fim_nota === 1'b1) fims++;
         prev = tocando;
      end
      checks++; if (rises !== 1) begin errors++; $display("FAIL same_notes: got %0d want 1", rises); end
      checks++; if (fims !== 1) begin errors++; $display("FAIL same_fims: got %0d want 1", fims); end
      settle_zero;
      arduino_in = 3'd4;
      n = 0;
      while (tocando !== 1'b1 && n < 30) begin
         tick;
         n++;
      end
      checks++; if (n !== 7 || nota !== 3'd4) begin errors++; $display("FAIL same_replay: edges=%0d nota=%0d want 7/4", n, nota); end
      n = 0;
      while (fim_nota !== 1'b1 && n < 200) begin
         tick;
         n++;
      end
      checks++; if (n !== 100) begin errors++; $display("FAIL same_replay_len: got %0d want 100", n); end
      $display("test_same_code: held code 4 gave %0d note, replay after 0 worked", rises);
      settle_zero;
   endtask

   task automatic test_reset_mid;
      int n;
      int fims;
      arduino_in = 3'd7;
      n = 0;
      while (tocando !== 1'b1 && n < 30) begin
         tick;
         n++;
      end
      checks++; if (n !== 7 || nota !== 3'd7) begin errors++; $display("FAIL mid_entry: edges=%0d nota=%0d want 7/7", n, nota); end
      repeat (49) tick;
      // 49 / 5 = 9 toggles so the tone is high just before reset
      checks++; if (buzzer !== 1'b1) begin errors++; $display("FAIL mid_prebuzzer: got %b want 1", buzzer); end
      reset = 1'b0;
      tick;
      checks++;
      if (buzzer !== 1'b0 || tocando !== 1'b0 || nota !== 3'd0 || fim_nota !== 1'b0 || db_estado !== 2'd0) begin
         errors++;
         $display("FAIL mid_reset: bz=%b toc=%b nota=%0d fim=%b st=%0d want all 0", buzzer, tocando, nota, fim_nota, db_estado);
      end
      arduino_in = 3'd0;
      tick;
      reset = 1'b1;
      fims = 0;
      repeat (120) begin
         tick;
         if (fim_nota === 1'b1) fims++;
      end
      checks++; if (fims !== 0) begin errors++; $display("FAIL mid_no_fim: got %0d pulses want 0", fims); end
      $display("test_reset_mid: note 7 aborted at cycle 50 without end pulse");
   endtask

   initial begin
      reset = 1'b0;
      arduino_in = 3'd0;
      test_reset;
      test_basic;
      test_glitch;
      test_retrigger;
      test_same_code;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
